// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - op codes, FSM states and default width for the MDU sequencer
package mdu_pkg;

    localparam int MDU_DATA_W = 32;

    localparam logic [2:0] MDU_MULT  = 3'b000;
    localparam logic [2:0] MDU_MULTU = 3'b001;
    localparam logic [2:0] MDU_DIV   = 3'b010;
    localparam logic [2:0] MDU_DIVU  = 3'b011;
    localparam logic [2:0] MDU_MTHI  = 3'b100;
    localparam logic [2:0] MDU_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

    // Signed variants (MULT, DIV) have op[0] clear within the arithmetic group.
    function automatic logic mdu_is_signed(input logic [2:0] op);
        return !op[2] && !op[0];
    endfunction

    function automatic logic mdu_is_div(input logic [2:0] op);
        return !op[2] && op[1];
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// rtl/mdu_div_step.sv - one restoring-division iteration on unsigned magnitudes
module mdu_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem_i,
    input  logic              bit_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] rem_o,
    output logic              q_bit_o
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;

    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted - {1'b0, divisor_i};
        q_bit_o = ~diff[DATA_W];
        rem_o   = q_bit_o ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    end

endmodule

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - iterative MULT/DIV sequencer owning HI/LO; MDU_ZERO_BYPASS_EN skips CALC on zero operands
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int DATA_W = MDU_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic              cancel,
    input  logic              mf_req,
    output logic              busy,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = $clog2(DATA_W);

    mdu_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   opb_q, opb_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                is_div_q, is_div_d;
    logic                neg_res_q, neg_res_d;
    logic                neg_rem_q, neg_rem_d;
    logic                dz_q, dz_d;
    logic                done_q, done_d;

    logic                sgn_op, div_op;
    logic [DATA_W-1:0]   mag_a, mag_b;
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_next, div_next, prod;
    logic [DATA_W-1:0]   div_rem, quo, rem;
    logic                div_qbit;

    always_comb begin
        sgn_op = mdu_is_signed(op);
        div_op = mdu_is_div(op);
        mag_a  = (sgn_op && rs_val[DATA_W-1]) ? -rs_val : rs_val;
        mag_b  = (sgn_op && rt_val[DATA_W-1]) ? -rt_val : rt_val;
    end

    // Divide keeps {remainder, dividend/quotient} in acc_q; quotient bits shift in at the bottom.
    mdu_div_step #(.DATA_W(DATA_W)) u_div_step (
        .rem_i     (acc_q[2*DATA_W-1:DATA_W]),
        .bit_i     (acc_q[DATA_W-1]),
        .divisor_i (opb_q),
        .rem_o     (div_rem),
        .q_bit_o   (div_qbit)
    );

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next = {mul_sum, acc_q[DATA_W-1:1]};
        div_next = {div_rem, acc_q[DATA_W-2:0], div_qbit};
        prod     = neg_res_q ? -acc_q : acc_q;
        quo      = neg_res_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
        rem      = neg_rem_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !cancel) begin
                    case (op)
                        MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                            state_d   = CALC;
                            cnt_d     = CNT_W'(DATA_W - 1);
                            is_div_d  = div_op;
                            acc_d     = {{DATA_W{1'b0}}, div_op ? mag_a : mag_b};
                            opb_d     = div_op ? mag_b : mag_a;
                            neg_res_d = sgn_op && (rs_val[DATA_W-1] ^ rt_val[DATA_W-1]);
                            neg_rem_d = sgn_op && div_op && rs_val[DATA_W-1];
                            dz_d      = div_op && (rt_val == '0);
`ifdef MDU_ZERO_BYPASS_EN
                            // Preload the final magnitudes so FIX sees what CALC would have left.
                            if (rs_val == '0 || rt_val == '0) begin
                                state_d = FIX;
                                acc_d   = (div_op && rt_val == '0) ? {mag_a, {DATA_W{1'b1}}} : '0;
                            end
`endif
                        end
                        MDU_MTHI: hi_d = rs_val;
                        MDU_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            CALC: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        lo_d = dz_q ? {DATA_W{1'b1}} : quo;
                        hi_d = rem;
                    end else begin
                        lo_d = prod[DATA_W-1:0];
                        hi_d = prod[2*DATA_W-1:DATA_W];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            done_q    <= done_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign stall = busy & (start | mf_req);
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule
